// File: rtl/bounce_gen_amisha_pkg.sv
// Shared constants for the switch-bounce emulator and the switch debouncer.
package bounce_gen_amisha_pkg;

  typedef logic [15:0] lfsr_t;

  // Emulator FSM encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BOUNCE = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  // Debouncer FSM encoding, kept here so both blocks share one package
  localparam logic [1:0] DB_STABLE_LO = 2'd0;
  localparam logic [1:0] DB_RISE      = 2'd1;
  localparam logic [1:0] DB_STABLE_HI = 2'd2;
  localparam logic [1:0] DB_FALL      = 2'd3;

  // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form (bits 15,13,12,10)
  localparam lfsr_t LFSR_TAPS    = 16'hB400;
  localparam lfsr_t SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/bounce_gen_amisha_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running outside reset; a zero seed is promoted to 1.
module lfsr16_amisha
  import bounce_gen_amisha_pkg::*;
#(
  parameter lfsr_t SEED = SEED_DEFAULT
) (
  input  logic        clk_amisha,
  input  logic        reset_n_amisha,
  output logic [15:0] q
);

  localparam lfsr_t SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  lfsr_t q_reg;
  lfsr_t q_next;
  logic  fb;

  assign fb        = ^(q_reg & LFSR_TAPS);
  assign q_next[0] = fb;

  genvar gi;
  generate
    for (gi = 1; gi < 16; gi++) begin : g_shift
      assign q_next[gi] = q_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk_amisha) begin
    if (!reset_n_amisha) begin
      q_reg <= SEED_EFF;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/bounce_gen_amisha.sv
// Switch-bounce emulator: turns a clean level request into an odd number of
// pseudo-randomly spaced toggles, then holds the settled level.
module bounce_gen_amisha
  import bounce_gen_amisha_pkg::*;
#(
  parameter int    GAP_SHIFT = 4,
  parameter int    SETTLE_W  = 21,
  parameter lfsr_t SEED      = SEED_DEFAULT
) (
  input  logic clk_amisha,
  input  logic reset_n_amisha,
  input  logic en_amisha,
  input  logic lvl_amisha,
  output logic sw_amisha,
  output logic busy_amisha,
  output logic done_amisha
);

  localparam int GAP_W = 9 + GAP_SHIFT;

  logic [15:0]         lfsr_q;
  logic                lfsr_unused;

  logic [1:0]          state_reg,     state_next;
  logic                sw_reg,        sw_next;
  logic                stable_reg,    stable_next;
  logic                target_reg,    target_next;
  logic                busy_reg,      busy_next;
  logic                done_reg,      done_next;
  logic [GAP_W-1:0]    gap_reg,       gap_next;
  logic [SETTLE_W-1:0] settle_reg,    settle_next;
  logic [3:0]          remaining_reg, remaining_next;
  logic [GAP_W-1:0]    gap_load;

  lfsr16_amisha #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_amisha     (clk_amisha),
    .reset_n_amisha (reset_n_amisha),
    .q              (lfsr_q)
  );

  // Only the low byte feeds the gap and burst length
  assign lfsr_unused = ^lfsr_q[15:8];

  // Loading G-1 makes the next toggle land exactly G cycles after this edge
  assign gap_load = ((GAP_W'(lfsr_q[7:0]) + GAP_W'(1)) << GAP_SHIFT) - GAP_W'(1);

  always_comb begin
    state_next     = state_reg;
    sw_next        = sw_reg;
    stable_next    = stable_reg;
    target_next    = target_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    gap_next       = gap_reg;
    settle_next    = settle_reg;
    remaining_next = remaining_reg;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (lvl_amisha != stable_reg) begin
          if (!en_amisha) begin
            sw_next     = lvl_amisha;
            stable_next = lvl_amisha;
            done_next   = 1'b1;
          end else begin
            // First toggle now; 2K more follow, so the total is odd
            target_next    = lvl_amisha;
            sw_next        = ~sw_reg;
            remaining_next = {lfsr_q[2:0], 1'b0};
            gap_next       = gap_load;
            busy_next      = 1'b1;
            state_next     = BOUNCE;
          end
        end
      end

      BOUNCE: begin
        if (gap_reg == '0) begin
          if (remaining_reg != 4'd0) begin
            sw_next        = ~sw_reg;
            remaining_next = remaining_reg - 4'd1;
            gap_next       = gap_load;
          end else begin
            settle_next = '1;
            state_next  = SETTLE;
          end
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end

      SETTLE: begin
        if (settle_reg == '0) begin
          stable_next = target_reg;
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = IDLE;
        end else begin
          settle_next = settle_reg - SETTLE_W'(1);
        end
      end

      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (!reset_n_amisha) begin
      state_reg     <= IDLE;
      sw_reg        <= 1'b0;
      stable_reg    <= 1'b0;
      target_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      gap_reg       <= '0;
      settle_reg    <= '0;
      remaining_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      sw_reg        <= sw_next;
      stable_reg    <= stable_next;
      target_reg    <= target_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      gap_reg       <= gap_next;
      settle_reg    <= settle_next;
      remaining_reg <= remaining_next;
    end
  end

  assign sw_amisha   = sw_reg;
  assign busy_amisha = busy_reg;
  assign done_amisha = done_reg;

endmodule

// File: tb/tb_bounce_gen_amisha.sv
// Bench for bounce_gen_amisha: predicts every toggle edge from an LFSR-over-time model.
module tb_bounce_gen_amisha;

  localparam int GS  = 0;
  localparam int STW = 4;

  logic clk_amisha     = 1'b0;
  logic reset_n_amisha = 1'b0;
  logic en_amisha      = 1'b0;
  logic lvl_amisha     = 1'b0;
  logic sw_amisha;
  logic busy_amisha;
  logic done_amisha;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  logic stable_m  = 1'b0;

  bounce_gen_amisha #(
    .GAP_SHIFT (GS),
    .SETTLE_W  (STW)
  ) dut (
    .clk_amisha     (clk_amisha),
    .reset_n_amisha (reset_n_amisha),
    .en_amisha      (en_amisha),
    .lvl_amisha     (lvl_amisha),
    .sw_amisha      (sw_amisha),
    .busy_amisha    (busy_amisha),
    .done_amisha    (done_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  // LFSR value present at the n-th edge after reset release
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    logic        fb;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      l  = {l[14:0], fb};
    end
    return l;
  endfunction

  // cyc counts non-reset edges; the edge just passed has index cyc-1
  task automatic tick();
    @(posedge clk_amisha);
    if (!reset_n_amisha) cyc = 0;
    else cyc++;
    #1;
  endtask

  // Expects a burst toward target to start on the next edge; optionally flips lvl after toggle flip_at
  task automatic run_burst(input logic target, input int flip_at);
    int          start, k, t, e, exp_done, done_seen, busy_bad, idx, budget;
    logic [15:0] l;
    int          exp_e[$];
    int          obs_e[$];
    logic        sw_prev, flipped, busy_exp;
    start = cyc;
    l     = lfsr_at(start);
    k     = int'(l[2:0]);
    t     = 2 * k + 1;
    e     = start;
    for (int i = 0; i < t; i++) begin
      exp_e.push_back(e);
      l = lfsr_at(e);
      e = e + ((int'(l[7:0]) + 1) << GS);
    end
    exp_done  = e + (1 << STW);
    budget    = exp_done - start + 50;
    done_seen = -1;
    busy_bad  = 0;
    flipped   = 1'b0;
    sw_prev   = sw_amisha;
    for (int n = 0; n < budget; n++) begin
      tick();
      idx = cyc - 1;
      if (sw_amisha !== sw_prev) obs_e.push_back(idx);
      sw_prev = sw_amisha;
      if (flip_at > 0 && !flipped && obs_e.size() == flip_at) begin
        lvl_amisha = ~target;
        flipped    = 1'b1;
      end
      busy_exp = (idx >= start) && (idx < exp_done);
      if (busy_amisha !== busy_exp) busy_bad++;
      if (done_amisha === 1'b1) begin
        done_seen = idx;
        break;
      end
    end
    $display("burst target=%0d start=%0d K=%0d toggles=%0d/%0d done_edge=%0d/%0d",
             target, start, k, obs_e.size(), t, done_seen, exp_done);
    total_cnt++;
    if (obs_e.size() !== t)
      $display("FAIL burst_toggle_count got=%0d want=%0d", obs_e.size(), t);
    else pass_cnt++;
    for (int i = 0; i < t && i < obs_e.size(); i++) begin
      total_cnt++;
      if (obs_e[i] !== exp_e[i])
        $display("FAIL burst_toggle_edge[%0d] got=%0d want=%0d", i, obs_e[i], exp_e[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (sw_amisha !== target)
      $display("FAIL burst_final_sw got=%0b want=%0b", sw_amisha, target);
    else pass_cnt++;
    total_cnt++;
    if (done_seen !== exp_done)
      $display("FAIL burst_done_edge got=%0d want=%0d", done_seen, exp_done);
    else pass_cnt++;
    total_cnt++;
    if (busy_bad !== 0)
      $display("FAIL burst_busy_window bad_cycles=%0d want=0", busy_bad);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n_amisha = 1'b0;
    en_amisha      = 1'b1;
    lvl_amisha     = 1'b1;
    tick();
    tick();
    $display("reset sw=%0b busy=%0b done=%0b lfsr=%h", sw_amisha, busy_amisha, done_amisha, dut.lfsr_q);
    total_cnt++;
    if (sw_amisha !== 1'b0) $display("FAIL reset_sw got=%0b want=0", sw_amisha);
    else pass_cnt++;
    total_cnt++;
    if (busy_amisha !== 1'b0) $display("FAIL reset_busy got=%0b want=0", busy_amisha);
    else pass_cnt++;
    total_cnt++;
    if (done_amisha !== 1'b0) $display("FAIL reset_done got=%0b want=0", done_amisha);
    else pass_cnt++;
    total_cnt++;
    if (dut.lfsr_q !== 16'hACE1) $display("FAIL reset_lfsr got=%h want=ace1", dut.lfsr_q);
    else pass_cnt++;
    stable_m       = 1'b0;
    reset_n_amisha = 1'b1;
    run_burst(1'b1, 0);
    stable_m = 1'b1;
  endtask

  task automatic test_pass_through();
    logic exp_done;
    en_amisha = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) lvl_amisha = ~stable_m;
      else lvl_amisha = 1'($urandom_range(0, 1));
      exp_done = (lvl_amisha != stable_m);
      stable_m = lvl_amisha;
      tick();
      $display("pass lvl=%0b sw=%0b done=%0b busy=%0b", lvl_amisha, sw_amisha, done_amisha, busy_amisha);
      total_cnt++;
      if (sw_amisha !== lvl_amisha) $display("FAIL pass_sw got=%0b want=%0b", sw_amisha, lvl_amisha);
      else pass_cnt++;
      total_cnt++;
      if (done_amisha !== exp_done) $display("FAIL pass_done got=%0b want=%0b", done_amisha, exp_done);
      else pass_cnt++;
      total_cnt++;
      if (busy_amisha !== 1'b0) $display("FAIL pass_busy got=%0b want=0", busy_amisha);
      else pass_cnt++;
    end
  endtask

  task automatic test_bounce_random();
    int idle;
    en_amisha = 1'b1;
    for (int b = 0; b < 4; b++) begin
      idle       = int'($urandom_range(0, 15));
      lvl_amisha = stable_m;
      for (int i = 0; i < idle; i++) tick();
      lvl_amisha = ~stable_m;
      run_burst(lvl_amisha, 0);
      stable_m = ~stable_m;
    end
  endtask

  // lvl reverts after the first toggle; the burst completes, then the next IDLE edge starts the return burst
  task automatic test_back_to_back();
    logic tgt;
    en_amisha  = 1'b1;
    tgt        = ~stable_m;
    lvl_amisha = tgt;
    run_burst(tgt, 1);
    stable_m = tgt;
    run_burst(~tgt, 0);
    stable_m = ~tgt;
  endtask

  task automatic test_mid_reset();
    int   toggles, dones;
    logic sw_prev;
    reset_n_amisha = 1'b0;
    en_amisha      = 1'b1;
    lvl_amisha     = 1'b0;
    tick();
    tick();
    reset_n_amisha = 1'b1;
    lvl_amisha     = 1'b1;
    toggles        = 0;
    dones          = 0;
    sw_prev        = sw_amisha;
    for (int n = 0; n < 3000 && toggles < 3; n++) begin
      tick();
      if (sw_amisha !== sw_prev) toggles++;
      if (done_amisha === 1'b1) dones++;
      sw_prev = sw_amisha;
    end
    total_cnt++;
    if (toggles !== 3) $display("FAIL mid_reset_toggles_reached got=%0d want=3", toggles);
    else pass_cnt++;
    reset_n_amisha = 1'b0;
    tick();
    if (done_amisha === 1'b1) dones++;
    $display("midreset sw=%0b busy=%0b done=%0b dones=%0d", sw_amisha, busy_amisha, done_amisha, dones);
    total_cnt++;
    if (sw_amisha !== 1'b0) $display("FAIL mid_reset_sw got=%0b want=0", sw_amisha);
    else pass_cnt++;
    total_cnt++;
    if (busy_amisha !== 1'b0) $display("FAIL mid_reset_busy got=%0b want=0", busy_amisha);
    else pass_cnt++;
    total_cnt++;
    if (dones !== 0) $display("FAIL mid_reset_no_done got=%0d want=0", dones);
    else pass_cnt++;
    stable_m       = 1'b0;
    reset_n_amisha = 1'b1;
    run_burst(1'b1, 0);
    stable_m = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_bounce_random();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
